// File: rtl/ppc_pkg.sv
// Shared PowerPC encodings, FSM state encoding, SPR numbers and decode record.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ppc_pkg;

  // Primary opcodes
  localparam logic [5:0] OPC_ADDI = 6'd14;
  localparam logic [5:0] OPC_BC   = 6'd16;
  localparam logic [5:0] OPC_SC   = 6'd17;
  localparam logic [5:0] OPC_B    = 6'd18;
  localparam logic [5:0] OPC_XL   = 6'd19;
  localparam logic [5:0] OPC_X31  = 6'd31;
  localparam logic [5:0] OPC_DS58 = 6'd58;

  // Extended opcodes
  localparam logic [8:0] XO9_ADD     = 9'd266;
  localparam logic [9:0] XO10_OR     = 10'd444;
  localparam logic [9:0] XO10_MTSPR  = 10'd467;
  localparam logic [9:0] XO10_BCLR   = 10'd16;
  localparam logic [9:0] XO10_BCCTR  = 10'd528;
  localparam logic [1:0] DSXO_LD     = 2'd0;
  localparam logic [1:0] DSXO_LDU    = 2'd1;

  // SPR numbers
  localparam logic [9:0] SPR_LR  = 10'd8;
  localparam logic [9:0] SPR_CTR = 10'd9;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_FETCH_WAIT,
    ST_EXEC,
    ST_LOAD,
    ST_LOAD_WAIT,
    ST_SC,
    ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_ILLEGAL,
    OP_ADD,
    OP_OR,
    OP_ADDI,
    OP_B,
    OP_BC,
    OP_BCLR,
    OP_BCCTR,
    OP_MTCTR,
    OP_LD,
    OP_SC
  } opKind_t;

  typedef struct packed {
    opKind_t     kind;
    logic        illegal;
    logic [4:0]  rt;      // rt / rs
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        oe;
    logic        rc;
    logic        lk;
    logic        aa;
    logic        isLdu;
    logic [4:0]  bo;      // bo[4] is BO[0] (big-endian numbering)
    logic [4:0]  bi;
    logic [63:0] imm;     // sign-extended SI, LI||00, BD||00 or DS||00
  } decode_t;

  // CR0 nibble {LT, GT, EQ, SO}
  function automatic logic [3:0] cr0Field(input logic [63:0] res, input logic so);
    return {res[63], ~res[63] & (res != 64'd0), res == 64'd0, so};
  endfunction

endpackage

// File: rtl/ppc_decode.sv
// Combinational instruction decoder: 32-bit instruction -> control record + illegal flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
// Ports: instr (big-endian word, bit 0 = instr[31]), dec (decoded control record).
module ppc_decode
  import ppc_pkg::*;
(
  input  logic [31:0] instr,
  output decode_t     dec
);

  logic [5:0] opcd;
  logic [8:0] xo9;
  logic [9:0] xo10;
  logic [9:0] sprNum;

  assign opcd   = instr[31:26];
  assign xo9    = instr[9:1];
  assign xo10   = instr[10:1];
  // SPR field is stored with its two 5-bit halves swapped
  assign sprNum = {instr[15:11], instr[20:16]};

  always_comb begin
    dec         = '0;
    dec.kind    = OP_ILLEGAL;
    dec.rt      = instr[25:21];
    dec.ra      = instr[20:16];
    dec.rb      = instr[15:11];
    dec.oe      = instr[10];
    dec.rc      = instr[0];
    dec.lk      = instr[0];
    dec.aa      = instr[1];
    dec.bo      = instr[25:21];
    dec.bi      = instr[20:16];
    dec.imm     = {{48{instr[15]}}, instr[15:0]};
    dec.isLdu   = 1'b0;

    case (opcd)
      OPC_X31: begin
        if (xo9 == XO9_ADD) begin
          dec.kind = OP_ADD;
        end else if (xo10 == XO10_OR) begin
          dec.kind = OP_OR;
        end else if (xo10 == XO10_MTSPR && sprNum == SPR_CTR) begin
          dec.kind = OP_MTCTR;
        end
      end
      OPC_ADDI: dec.kind = OP_ADDI;
      OPC_B: begin
        dec.kind = OP_B;
        dec.imm  = {{38{instr[25]}}, instr[25:2], 2'b00};
      end
      OPC_BC: begin
        dec.kind = OP_BC;
        dec.imm  = {{48{instr[15]}}, instr[15:2], 2'b00};
      end
      OPC_XL: begin
        if (xo10 == XO10_BCLR) begin
          dec.kind = OP_BCLR;
        end else if (xo10 == XO10_BCCTR && instr[23]) begin
          // bcctr may not decrement CTR: BO[2]=0 is undefined
          dec.kind = OP_BCCTR;
        end
      end
      OPC_DS58: begin
        dec.imm = {{48{instr[15]}}, instr[15:2], 2'b00};
        if (instr[1:0] == DSXO_LD) begin
          dec.kind = OP_LD;
        end else if (instr[1:0] == DSXO_LDU && dec.ra != 5'd0 && dec.ra != dec.rt) begin
          dec.kind  = OP_LD;
          dec.isLdu = 1'b1;
        end
      end
      OPC_SC:  dec.kind = OP_SC;
      default: dec.kind = OP_ILLEGAL;
    endcase

    dec.illegal = (dec.kind == OP_ILLEGAL);
  end

endmodule

// File: rtl/ppc_mc_core.sv
// Multi-cycle 64-bit PowerPC subset core: fetch, execute, optional load or syscall event.
// Latency: fetch accept -> EXEC = response arrival + 1; ALU/branch retire in 1 EXEC cycle.
// Backpressure: mem requests held stable until mem_req_ready; sc event held until sc_ready.
// Ports: clk/reset (sync, active-high); mem_req_* doubleword request (one outstanding);
//        mem_rsp_* read data; sc_* syscall event (code=GPR0, data=GPR3); halted/illegal status.
module ppc_mc_core
  import ppc_pkg::*;
#(
  parameter logic [63:0] RESET_PC        = 64'h0,
  parameter int          HALT_ON_ILLEGAL = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [60:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rsp_data,
  output logic        sc_valid,
  input  logic        sc_ready,
  output logic [63:0] sc_code,
  output logic [63:0] sc_data,
  output logic        halted,
  output logic        illegal
);

  state_t      state, stateNext;
  logic [63:0] pc, pcNext, lr, lrNext, ctr, ctrNext;
  logic [31:0] cr, crNext;
  logic [31:0] instr, instrNext;
  logic        instrLoad;
  logic        xerSo, soNext, xerOv, ovNext;
  logic        illegalFlag, illNext;
  logic [63:0] gpr [32];

  decode_t     dec;

  logic        wrEn, wr2En;
  logic [4:0]  wrAddr, wr2Addr;
  logic [63:0] wrData, wr2Data;
  logic        reqVld, scVld;
  logic [60:0] reqAddr;

  logic [63:0] aVal, bVal, sVal, raOrZero, sum, orRes, ea, ctrDec, brTarget, linkPc;
  logic        ovf, soAfter, crSel, ctrOk, condOk;

  ppc_decode u_decode (
    .instr (instr),
    .dec   (dec)
  );

  // Operand and datapath values, all derived from the held instruction
  assign aVal     = gpr[dec.ra];
  assign bVal     = gpr[dec.rb];
  assign sVal     = gpr[dec.rt];
  assign raOrZero = (dec.ra == 5'd0) ? 64'd0 : aVal;
  assign sum      = aVal + bVal;
  assign orRes    = sVal | bVal;
  assign ovf      = (aVal[63] == bVal[63]) && (sum[63] != aVal[63]);
  assign soAfter  = dec.oe ? (xerSo | ovf) : xerSo;
  // GPRs are untouched between EXEC and LOAD_WAIT, so EA stays stable without a register
  assign ea       = raOrZero + dec.imm;
  assign ctrDec   = ctr - 64'd1;
  assign linkPc   = pc + 64'd4;
  assign brTarget = dec.aa ? dec.imm : (pc + dec.imm);
  // CR bit BI in big-endian numbering lives at cr[31-BI]
  assign crSel    = cr[~dec.bi];
  assign ctrOk    = dec.bo[2] | ((ctrDec != 64'd0) ^ dec.bo[1]);
  assign condOk   = dec.bo[4] | (crSel == dec.bo[3]);

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    lrNext    = lr;
    ctrNext   = ctr;
    crNext    = cr;
    soNext    = xerSo;
    ovNext    = xerOv;
    illNext   = illegalFlag;
    instrLoad = 1'b0;
    instrNext = pc[2] ? mem_rsp_data[31:0] : mem_rsp_data[63:32];
    wrEn      = 1'b0;
    wrAddr    = dec.rt;
    wrData    = 64'd0;
    wr2En     = 1'b0;
    wr2Addr   = dec.ra;
    wr2Data   = ea;
    reqVld    = 1'b0;
    reqAddr   = 61'd0;
    scVld     = 1'b0;

    case (state)
      ST_FETCH: begin
        reqVld  = 1'b1;
        reqAddr = pc[63:3];
        if (mem_req_ready) stateNext = ST_FETCH_WAIT;
      end

      ST_FETCH_WAIT: begin
        if (mem_rsp_valid) begin
          instrLoad = 1'b1;
          stateNext = ST_EXEC;
        end
      end

      ST_EXEC: begin
        pcNext    = linkPc;
        stateNext = ST_FETCH;
        if (dec.illegal) begin
          if (HALT_ON_ILLEGAL != 0) begin
            pcNext    = pc;
            illNext   = 1'b1;
            stateNext = ST_HALT;
          end
        end else begin
          case (dec.kind)
            OP_ADD: begin
              wrEn   = 1'b1;
              wrData = sum;
              if (dec.oe) begin
                ovNext = ovf;
                soNext = soAfter;
              end
              if (dec.rc) crNext[31:28] = cr0Field(sum, soAfter);
            end
            OP_OR: begin
              wrEn   = 1'b1;
              wrAddr = dec.ra;
              wrData = orRes;
              if (dec.rc) crNext[31:28] = cr0Field(orRes, xerSo);
            end
            OP_ADDI: begin
              wrEn   = 1'b1;
              wrData = raOrZero + dec.imm;
            end
            OP_B: begin
              if (dec.lk) lrNext = linkPc;
              pcNext = brTarget;
            end
            OP_BC: begin
              if (!dec.bo[2]) ctrNext = ctrDec;
              if (dec.lk) lrNext = linkPc;
              if (ctrOk && condOk) pcNext = brTarget;
            end
            OP_BCLR: begin
              // target uses the pre-update LR even when LK=1
              if (!dec.bo[2]) ctrNext = ctrDec;
              if (dec.lk) lrNext = linkPc;
              if (ctrOk && condOk) pcNext = {lr[63:2], 2'b00};
            end
            OP_BCCTR: begin
              if (dec.lk) lrNext = linkPc;
              if (condOk) pcNext = {ctr[63:2], 2'b00};
            end
            OP_MTCTR: ctrNext   = sVal;
            OP_LD:    stateNext = ST_LOAD;
            OP_SC:    stateNext = ST_SC;
            default:  ;
          endcase
        end
      end

      ST_LOAD: begin
        reqVld  = 1'b1;
        reqAddr = ea[63:3];
        if (mem_req_ready) stateNext = ST_LOAD_WAIT;
      end

      ST_LOAD_WAIT: begin
        if (mem_rsp_valid) begin
          wrEn      = 1'b1;
          wrData    = mem_rsp_data;
          wr2En     = dec.isLdu;
          stateNext = ST_FETCH;
        end
      end

      ST_SC: begin
        scVld = 1'b1;
        if (sc_ready) stateNext = (gpr[0] == 64'd1) ? ST_HALT : ST_FETCH;
      end

      ST_HALT: ;

      default: stateNext = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      lr          <= 64'd0;
      ctr         <= 64'd0;
      cr          <= 32'd0;
      xerSo       <= 1'b0;
      xerOv       <= 1'b0;
      illegalFlag <= 1'b0;
      instr       <= 32'd0;
      for (int i = 0; i < 32; i++) gpr[i] <= 64'd0;
    end else begin
      state       <= stateNext;
      pc          <= pcNext;
      lr          <= lrNext;
      ctr         <= ctrNext;
      cr          <= crNext;
      xerSo       <= soNext;
      xerOv       <= ovNext;
      illegalFlag <= illNext;
      if (instrLoad) instr <= instrNext;
      if (wrEn)  gpr[wrAddr]  <= wrData;
      if (wr2En) gpr[wr2Addr] <= wr2Data;
    end
  end

  // Reset forces every output low in the same cycle it is asserted
  assign mem_req_valid = reqVld & ~reset;
  assign mem_req_addr  = (reqVld & ~reset) ? reqAddr : 61'd0;
  assign sc_valid      = scVld & ~reset;
  assign sc_code       = (scVld & ~reset) ? gpr[0] : 64'd0;
  assign sc_data       = (scVld & ~reset) ? gpr[3] : 64'd0;
  assign halted        = (state == ST_HALT) & ~reset;
  assign illegal       = illegalFlag & ~reset;

endmodule

// File: tb/tb_ppc_mc_core.sv
// Directed bench for ppc_mc_core with a one-cycle-latency memory model.
// Latency: n/a.
// Backpressure: mem_req_ready and sc_ready are driven by the directed steps.
module tb_ppc_mc_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [60:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [63:0] mem_rsp_data = 64'd0;
  logic        sc_valid;
  logic        sc_ready = 1'b1;
  logic [63:0] sc_code;
  logic [63:0] sc_data;
  logic        halted;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  logic [63:0] mem [256];
  int          reqCount = 0;
  logic        rspHit;
  logic [60:0] rspAddr;
  logic        dropRsp = 1'b0;
  logic        injectStale = 1'b0;

  ppc_mc_core dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .sc_valid      (sc_valid),
    .sc_ready      (sc_ready),
    .sc_code       (sc_code),
    .sc_data       (sc_data),
    .halted        (halted),
    .illegal       (illegal)
  );

  always #5 clk = ~clk;

  // Memory model: answers an accepted request one cycle later
  always @(posedge clk) begin
    rspHit  = mem_req_valid && mem_req_ready && !reset;
    rspAddr = mem_req_addr;
    if (rspHit) reqCount++;
    #1;
    if (injectStale) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'd0;
    end else begin
      mem_rsp_valid = rspHit && !(dropRsp && rspAddr == 61'h40);
      mem_rsp_data  = rspHit ? mem[rspAddr[7:0]] : 64'd0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] iAddi(input logic [4:0] rt, input logic [4:0] ra, input logic [15:0] si);
    return {6'd14, rt, ra, si};
  endfunction
  function automatic logic [31:0] iAdd(input logic [4:0] rt, input logic [4:0] ra, input logic [4:0] rb,
                                       input logic oe, input logic rc);
    return {6'd31, rt, ra, rb, oe, 9'd266, rc};
  endfunction
  function automatic logic [31:0] iMtctr(input logic [4:0] rs);
    return {6'd31, rs, 5'd9, 5'd0, 10'd467, 1'b0};
  endfunction
  function automatic logic [31:0] iBc(input logic [4:0] bo, input logic [4:0] bi, input logic [15:0] bd);
    return {6'd16, bo, bi, bd[15:2], 2'b00};
  endfunction
  function automatic logic [31:0] iBl(input logic [25:0] li);
    return {6'd18, li[25:2], 2'b01};
  endfunction
  function automatic logic [31:0] iBclrl(input logic [4:0] bo, input logic [4:0] bi);
    return {6'd19, bo, bi, 5'd0, 10'd16, 1'b1};
  endfunction
  function automatic logic [31:0] iLd(input logic [4:0] rt, input logic [4:0] ra, input logic [15:0] ds,
                                      input logic [1:0] xo);
    return {6'd58, rt, ra, ds[15:2], xo};
  endfunction

  localparam logic [31:0] SC_INSN = 32'h4400_0002;

  task automatic clearMem();
    for (int i = 0; i < 256; i++) mem[i] = 64'd0;
  endtask

  task automatic putI(input logic [10:0] addr, input logic [31:0] w);
    if (addr[2]) mem[addr[10:3]][31:0]  = w;
    else         mem[addr[10:3]][63:32] = w;
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic waitHalt(input string tag);
    int n = 0;
    while (!halted && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(halted), 64'd1);
  endtask

  initial begin
    int n;
    int snap;

    // ---- Segment 1: reset state, addi -1 then add. ----
    clearMem();
    putI(11'h00, iAddi(5'd3, 5'd0, 16'hFFFF));
    putI(11'h04, iAdd(5'd4, 5'd3, 5'd3, 1'b0, 1'b1));
    putI(11'h08, iAddi(5'd0, 5'd0, 16'd1));
    putI(11'h0C, SC_INSN);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst mem_req_addr",  64'(mem_req_addr),  64'd0);
    chk("rst sc_valid",      64'(sc_valid),      64'd0);
    chk("rst halted",        64'(halted),        64'd0);
    chk("rst illegal",       64'(illegal),       64'd0);
    reset = 1'b0;
    #1;
    chk("post-rst req valid", 64'(mem_req_valid), 64'd1);
    chk("post-rst req addr",  64'(mem_req_addr),  64'd0);
    waitHalt("s1 halted");
    chk("s1 r3", dut.gpr[3], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("s1 r4", dut.gpr[4], 64'hFFFF_FFFF_FFFF_FFFE);
    chk("s1 cr0", 64'(dut.cr[31:28]), 64'h8);
    chk("s1 illegal", 64'(illegal), 64'd0);

    // ---- Segment 2: addo. overflow, delayed sc, sticky SO, sc halt ----
    clearMem();
    putI(11'h00, iLd(5'd1, 5'd0, 16'h0200, 2'd0));
    putI(11'h04, iAdd(5'd2, 5'd1, 5'd1, 1'b1, 1'b1));
    putI(11'h08, iAddi(5'd3, 5'd0, 16'h0041));
    putI(11'h0C, SC_INSN);
    putI(11'h10, iAdd(5'd5, 5'd6, 5'd6, 1'b0, 1'b1));
    putI(11'h14, iAddi(5'd0, 5'd0, 16'd1));
    putI(11'h18, SC_INSN);
    mem[8'h40] = 64'h7FFF_FFFF_FFFF_FFFF;
    sc_ready = 1'b0;
    doReset();
    n = 0;
    while (!sc_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("s2 sc_valid", 64'(sc_valid), 64'd1);
    chk("s2 sc_code", sc_code, 64'd0);
    chk("s2 sc_data", sc_data, 64'h41);
    chk("s2 r1", dut.gpr[1], 64'h7FFF_FFFF_FFFF_FFFF);
    chk("s2 r2", dut.gpr[2], 64'hFFFF_FFFF_FFFF_FFFE);
    chk("s2 ov", 64'(dut.xerOv), 64'd1);
    chk("s2 so", 64'(dut.xerSo), 64'd1);
    chk("s2 cr0 addo.", 64'(dut.cr[31:28]), 64'h9);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("s2 sc_valid held", 64'(sc_valid), 64'd1);
      chk("s2 sc_data held", sc_data, 64'h41);
      chk("s2 no req during sc", 64'(mem_req_valid), 64'd0);
    end
    snap = reqCount;
    sc_ready = 1'b1;
    @(negedge clk);
    chk("s2 sc released", 64'(sc_valid), 64'd0);
    chk("s2 fetch resumes", 64'(mem_req_valid), 64'd1);
    chk("s2 resume addr", 64'(mem_req_addr), 64'h2);
    waitHalt("s2 halted");
    chk("s2 resumed reqs", 64'(reqCount > snap), 64'd1);
    chk("s2 r5", dut.gpr[5], 64'd0);
    chk("s2 cr0 zero", 64'(dut.cr[31:28]), 64'h3);
    snap = reqCount;
    repeat (10) @(negedge clk);
    chk("s2 halt no req", 64'(mem_req_valid), 64'd0);
    chk("s2 halt req count", 64'(reqCount), 64'(snap));

    // ---- Segment 3: CTR loop, bl, bclrl using old LR ----
    clearMem();
    putI(11'h00, iAddi(5'd7, 5'd0, 16'd3));
    putI(11'h04, iMtctr(5'd7));
    putI(11'h08, iAddi(5'd8, 5'd8, 16'd1));
    putI(11'h0C, iBc(5'd16, 5'd0, 16'hFFFC));
    putI(11'h10, iBl(26'h10));
    putI(11'h14, iAddi(5'd0, 5'd0, 16'd1));
    putI(11'h18, SC_INSN);
    putI(11'h20, iAddi(5'd9, 5'd0, 16'd5));
    putI(11'h24, iBclrl(5'd20, 5'd0));
    doReset();
    waitHalt("s3 halted");
    chk("s3 loop count r8", dut.gpr[8], 64'd3);
    chk("s3 ctr", dut.ctr, 64'd0);
    chk("s3 r9", dut.gpr[9], 64'd5);
    chk("s3 lr", dut.lr, 64'h28);

    // ---- Segment 4: ldu with stalled request ----
    clearMem();
    putI(11'h00, iAddi(5'd6, 5'd0, 16'h0100));
    putI(11'h04, iLd(5'd5, 5'd6, 16'd8, 2'd1));
    putI(11'h08, iAddi(5'd0, 5'd0, 16'd1));
    putI(11'h0C, SC_INSN);
    mem[8'h21] = 64'hDEAD_BEEF_0123_4567;
    doReset();
    n = 0;
    while (!(mem_req_valid && mem_req_addr == 61'h21) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("s4 load req seen", 64'(mem_req_addr), 64'h21);
    mem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("s4 stall valid", 64'(mem_req_valid), 64'd1);
      chk("s4 stall addr", 64'(mem_req_addr), 64'h21);
    end
    mem_req_ready = 1'b1;
    waitHalt("s4 halted");
    chk("s4 r5", dut.gpr[5], 64'hDEAD_BEEF_0123_4567);
    chk("s4 r6", dut.gpr[6], 64'h108);

    // ---- Segment 5: illegal opcode 0 ----
    clearMem();
    putI(11'h00, iAddi(5'd3, 5'd0, 16'd7));
    doReset();
    waitHalt("s5 halted");
    chk("s5 illegal", 64'(illegal), 64'd1);
    chk("s5 r3", dut.gpr[3], 64'd7);
    snap = reqCount;
    repeat (8) @(negedge clk);
    chk("s5 halt req count", 64'(reqCount), 64'(snap));

    // ---- Segment 6: reset during LOAD_WAIT, stale response ignored ----
    clearMem();
    putI(11'h00, iLd(5'd1, 5'd0, 16'h0200, 2'd0));
    putI(11'h04, iAddi(5'd0, 5'd0, 16'd1));
    putI(11'h08, SC_INSN);
    mem[8'h40] = 64'h0123_4567_89AB_CDEF;
    dropRsp = 1'b1;
    doReset();
    n = 0;
    while (!(mem_req_valid && mem_req_addr == 61'h40) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("s6 load req seen", 64'(mem_req_addr), 64'h40);
    repeat (2) @(negedge clk);
    chk("s6 waiting", 64'(mem_req_valid), 64'd0);
    mem_req_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dropRsp = 1'b0;
    injectStale = 1'b1;
    @(negedge clk);
    chk("s6 refetch valid", 64'(mem_req_valid), 64'd1);
    chk("s6 refetch addr", 64'(mem_req_addr), 64'd0);
    @(negedge clk);
    injectStale = 1'b0;
    chk("s6 stale ignored addr", 64'(mem_req_addr), 64'd0);
    mem_req_ready = 1'b1;
    waitHalt("s6 halted");
    chk("s6 illegal", 64'(illegal), 64'd0);
    chk("s6 r1", dut.gpr[1], 64'h0123_4567_89AB_CDEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppc_mc_core.md
PPC_MC_CORE -- requirements
Module: ppc_mc_core

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning fetch address loaded on reset.
REQ-002 SHALL have parameter HALT_ON_ILLEGAL, default 1, meaning 1 halts on undecodable instruction and 0 treats it as a no-op.
REQ-003 SHALL have ports:
- clk  in  1  sole clock; all state on posedge.
- reset  in  1  synchronous, active-high.
- mem_req_valid  out  1  memory request pending.
- mem_req_ready  in  1  memory accepts request this cycle.
- mem_req_addr  out  61  doubleword address, big-endian bit order [0:60].
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_data  in  64  doubleword, big-endian [0:63].
- sc_valid  out  1  system-call event pending.
- sc_ready  in  1  consumer accepts event.
- sc_code  out  64  GPR0 at sc.
- sc_data  out  64  GPR3 at sc.
- halted  out  1  core stopped.
- illegal  out  1  halt caused by illegal instruction.

Function
REQ-004 SHALL run FSM FETCH -> FETCH_WAIT -> EXEC -> {FETCH | LOAD -> LOAD_WAIT -> FETCH | SC -> FETCH | HALT}.
REQ-005 SHALL in FETCH drive mem_req_valid=1, mem_req_addr=pc[0:60], and move to FETCH_WAIT on mem_req_valid & mem_req_ready.
REQ-006 SHALL hold mem_req_valid and mem_req_addr stable until accepted, with at most one request outstanding.
REQ-007 SHALL in FETCH_WAIT latch the instruction as mem_rsp_data[32:63] when pc[61]=1, else [0:31], and ignore mem_rsp_valid in every other state.
REQ-008 SHALL decode add/add./addo/addo. (op31 xo9 266), or/or. (op31 xo10 444), addi (op14), b/ba/bl/bla (op18), bc/bca/bcl/bcla (op16), bclr[l] (op19 xo10 16), bcctr[l] (op19 xo10 528), mtctr (op31 xo10 467, spr=9), ld (op58 ds-form xo 0), ldu (op58 xo 1) and sc (op17).
REQ-009 SHALL treat every other encoding as illegal, including ldu with ra=0 or ra=rt, and bcctr with BO[2]=0.
REQ-010 SHALL compute all arithmetic modulo 2^64, with PC advancing by 4 when not branching.
REQ-011 SHALL make addi use 0 for ra=0, and ld use 0 for ra=0; ld EA = (ra|0)+EXTS(DS||00).
REQ-012 SHALL have or write rA = rS|rB.
REQ-013 SHALL set CR0 on Rc=1 as LT=res[0], GT=~res[0]&res!=0, EQ=res==0, SO=XER.SO after this instruction's update.
REQ-014 SHALL set XER.OV on OE=1 to signed overflow, with XER.SO sticky-OR of OV.
REQ-015 SHALL for bc/bclr decrement CTR when BO[2]=0 (using ctr_ok = BO[2] | ((CTR-1 != 0) ^ BO[3]) and cond_ok = BO[0] | (CR[BI] == BO[1])), and take the branch when ctr_ok & cond_ok.
REQ-016 SHALL make bcctr target CTR[0:61]||00.
REQ-017 SHALL make bclr target LR[0:61]||00, using the LR value before any same-instruction LK update.
REQ-018 SHALL write LR = pc+4 when LK=1, whether or not the branch is taken.
REQ-019 SHALL in LOAD issue a request at EA[0:60] with the same handshake as FETCH.
REQ-020 SHALL in LOAD_WAIT write rt = mem_rsp_data, and for ldu also write ra = EA in the same cycle.
REQ-021 SHALL in SC hold sc_valid=1 with sc_code/sc_data stable until sc_ready, then enter HALT if sc_code==1, else FETCH.
REQ-022 SHALL in HALT hold halted=1, issue no requests and hold all state until reset.
REQ-023 SHALL give latency of FETCH accept -> EXEC as response arrival + 1 cycle; ALU/branch retire in EXEC (1 cycle).

Reset
REQ-024 SHALL on reset=1 at posedge set pc=RESET_PC, all 32 GPRs, LR, CTR, CR and XER to 0, state FETCH and every output 0.
REQ-025 SHALL have reset during FETCH_WAIT or LOAD_WAIT abandon the outstanding transaction, with any response arriving in the next FETCH state ignored until the new request is accepted.
REQ-026 SHALL have reset dominate sc_ready and mem handshakes in the same cycle.

Structure
REQ-027 SHALL place opcode/extended-opcode constants, FSM state encoding and SPR numbers in shared package ppc_pkg.
REQ-028 SHALL have a single sub-module ppc_decode (combinational instruction -> control fields and illegal flag).
REQ-029 SHALL keep the register file and FSM in ppc_mc_core.

Verification
REQ-030 SHALL cover: addi r3,0,-1 then add. r4,r3,r3 -> r4=0xFFFF_FFFF_FFFF_FFFE, CR0=LT (1000).
REQ-031 SHALL cover: r1=0x7FFF_FFFF_FFFF_FFFF, addo. r2,r1,r1 -> OV=1, SO=1, CR0=1001; a later add. with result 0 -> CR0=0011.
REQ-032 SHALL cover: mtctr 3, bc BO=16 back-branch loop -> body executes 3 times, CTR=0 at exit.
REQ-033 SHALL cover: ldu r5,8(r6) with r6=0x100, mem_req_ready low 4 cycles -> address stable throughout, r5=data@0x108, r6=0x108.
REQ-034 SHALL cover: r0=0, r3=0x41, sc with sc_ready delayed 3 cycles -> sc_valid held, then fetch resumes; r0=1, sc -> halted=1, no further requests.
REQ-035 SHALL cover: illegal opcode 0 with HALT_ON_ILLEGAL=1 -> halted=1, illegal=1; reset asserted mid-LOAD_WAIT -> next request is fetch at RESET_PC.
